approx_mul_err_monitor: RTL and testbench
=========================================

// Module: approx_mul_err_monitor
// PURPOSE
//  Downstream consumer of the 2N-bit approximate recursive multiplier product.
//  Takes operands a, b and the multiplier's y_approx through a valid/ready handshake.
//  Computes the exact product internally and the error distance ED = |a*b - y_approx|.
//  Over a window of WIN samples it accumulates the error count, the ED sum and the ED maximum.
//  Used by characterisation benches and on-chip self-test to score approximate designs.
// PARAMETERS
//  N      4    operand width; the product is 2N bits
//  WIN    256  samples per measurement window; legal range WIN >= 1
//  W_ACC  16   width of the ED-sum accumulator
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      begin a window; honoured only in IDLE
//  in_valid   in   1      a, b and y_approx are valid this cycle
//  in_ready   out  1      block accepts a sample this cycle
//  a          in   N      operand A
//  b          in   N      operand B
//  y_approx   in   2N     approximate product under test
//  busy       out  1      high in ACC
//  done       out  1      one-cycle pulse at window end
//  err_count  out  CW     samples with ED != 0; CW = $clog2(WIN+1)
//  sum_ed     out  W_ACC  saturating sum of ED
//  max_ed     out  2N     largest ED in the window
//  sat        out  1      sticky: sum_ed has saturated in this window
// BEHAVIOUR
//  Reset:
//   - Asynchronous reset drives state to IDLE.
//   - All outputs go to 0, including in_ready, busy and done.
//  States: IDLE -> ACC -> RPT -> IDLE.
//   - IDLE: in_ready=0. start=1 clears the sample counter, err_count, sum_ed, max_ed and sat, then enters ACC.
//   - ACC: busy=1, in_ready=1. A sample is accepted when in_valid && in_ready.
//     Cycles with in_valid=0 are idle and leave all state unchanged.
//   - The WIN-th accepted sample is accumulated and the state moves to RPT on the same edge.
//   - RPT: lasts exactly 1 cycle with done=1 and in_ready=0, then returns to IDLE.
//  Latency: results include an accepted sample on the edge that accepts it.
//   - done is asserted the cycle after the WIN-th accept.
//  Arithmetic:
//   - Exact product is 2N bits, unsigned.
//   - ED is computed at 2N+1 bits as a signed difference, then its absolute value is taken.
//   - The result fits 2N bits; it is truncated to 2N bits for max_ed.
//   - sum_ed += ED. If the true sum exceeds 2^W_ACC-1, sum_ed clamps to all-ones and sat=1.
//     sat stays set until the next start.
//   - err_count increments when ED != 0. It cannot overflow, since CW covers WIN.
//   - max_ed updates when ED > max_ed; on a tie it holds its value.
//  Boundaries:
//   - start in ACC or RPT is ignored.
//   - start in the same cycle as the RPT->IDLE return is ignored; a new start is needed in IDLE.
//   - Results hold stable in IDLE until the next honoured start.
//   - WIN=1: one accept goes ACC -> RPT.
//   - Reset mid-window abandons the window; there is no done pulse.
// CONFIGURATION
//  SIGNED_ERR_EN defined:
//   - Adds output sum_se (W_ACC+1 bits, signed).
//   - sum_se is the saturating sum of (exact - y_approx), i.e. the bias.
//   - It clamps at the signed max/min and sets sat.
//   - It is cleared by start and by reset.
//  SIGNED_ERR_EN undefined: port and logic are absent; all else is identical.
// TESTING
//  - Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately; in_ready=0.
//  - WIN=4; samples (3,3,7), (2,2,4), (15,15,175), (1,0,0):
//    -> err_count=2, sum_ed=52, max_ed=50; done pulses 1 cycle after the 4th accept.
//  - WIN=256, exhaustive 4x4 sweep through the approximate multiplier:
//    -> err_count=49, max_ed=50 (15x15 case), sat=0.
//  - W_ACC=6; two samples with ED=50 -> sum_ed=63, sat=1; the next start clears sat.
//  - in_valid gaps plus start pulses during ACC/RPT -> counts unchanged; no restart; exactly one done.
//  - Reset after 2 of 4 samples, then a new start -> no done from the first window;
//    the second window's results exclude the earlier samples.

Source files
------------

// File: rtl/approx_mul_err_monitor.sv
// Error-distance monitor for a 2N-bit approximate multiplier: scores WIN samples per window.
// Optional SIGNED_ERR_EN adds the saturating signed bias accumulator sum_se.
module approx_mul_err_monitor #(
    parameter  int N     = 4,
    parameter  int WIN   = 256,
    parameter  int W_ACC = 16,
    localparam int CW    = $clog2(WIN + 1),
    localparam int PW    = 2 * N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [PW-1:0]    y_approx,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    err_count,
    output logic [W_ACC-1:0] sum_ed,
    output logic [PW-1:0]    max_ed,
`ifdef SIGNED_ERR_EN
    output logic signed [W_ACC:0] sum_se,
`endif
    output logic             sat
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RPT  = 2'd2
    } state_e;

    // Wide enough that the unsigned sum of the old total and one ED cannot wrap
    localparam int SW = ((W_ACC > PW) ? W_ACC : PW) + 1;
    localparam logic [SW-1:0] SUM_MAX = {{(SW - W_ACC){1'b0}}, {W_ACC{1'b1}}};

    function automatic logic [PW-1:0] abs_diff(input logic signed [PW:0] d);
        return d[PW] ? PW'(-d) : PW'(d);
    endfunction

    state_e                   state_q;
    logic                     busy_q;
    logic                     done_q;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            err_q, err_d;
    logic [W_ACC-1:0]         sum_q, sum_d;
    logic [PW-1:0]            max_q, max_d;
    logic                     sat_q, sat_d;
    logic [PW-1:0]            exact_s;
    logic signed [PW:0]       diff_s;
    logic [PW-1:0]            ed_s;
    logic [SW-1:0]            sum_ext_s;
    logic                     sum_sat_s;
    logic                     last_s;

`ifdef SIGNED_ERR_EN
    localparam int SSW = ((W_ACC > PW) ? W_ACC : PW) + 2;
    localparam logic signed [SSW-1:0] SE_MAX = SSW'($signed({1'b0, {W_ACC{1'b1}}}));
    localparam logic signed [SSW-1:0] SE_MIN = SSW'($signed({1'b1, {W_ACC{1'b0}}}));

    logic signed [W_ACC:0]    se_q, se_d;
    logic signed [SSW-1:0]    se_ext_s;
    logic                     se_sat_s;
`endif

    // Per-sample arithmetic and next values of the window statistics
    always_comb begin
        exact_s   = PW'(a) * PW'(b);
        diff_s    = $signed({1'b0, exact_s}) - $signed({1'b0, y_approx});
        ed_s      = abs_diff(diff_s);
        sum_ext_s = SW'(sum_q) + SW'(ed_s);
        if (sum_ext_s > SUM_MAX) begin
            sum_d     = '1;
            sum_sat_s = 1'b1;
        end else begin
            sum_d     = sum_ext_s[W_ACC-1:0];
            sum_sat_s = 1'b0;
        end
        if (ed_s != '0) begin
            err_d = err_q + CW'(1);
        end else begin
            err_d = err_q;
        end
        // A tie leaves max_ed untouched
        if (ed_s > max_q) begin
            max_d = ed_s;
        end else begin
            max_d = max_q;
        end
        cnt_d  = cnt_q + CW'(1);
        last_s = (cnt_q == CW'(WIN - 1));
`ifdef SIGNED_ERR_EN
        se_ext_s = SSW'(se_q) + SSW'(diff_s);
        if (se_ext_s > SE_MAX) begin
            se_d     = SE_MAX[W_ACC:0];
            se_sat_s = 1'b1;
        end else if (se_ext_s < SE_MIN) begin
            se_d     = SE_MIN[W_ACC:0];
            se_sat_s = 1'b1;
        end else begin
            se_d     = se_ext_s[W_ACC:0];
            se_sat_s = 1'b0;
        end
        sat_d = sat_q | sum_sat_s | se_sat_s;
`else
        sat_d = sat_q | sum_sat_s;
`endif
    end

    // Window FSM with registered status flags and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            sat_q   <= 1'b0;
`ifdef SIGNED_ERR_EN
            se_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_ACC;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        err_q   <= '0;
                        sum_q   <= '0;
                        max_q   <= '0;
                        sat_q   <= 1'b0;
`ifdef SIGNED_ERR_EN
                        se_q    <= '0;
`endif
                    end
                end
                ST_ACC: begin
                    // in_ready is high throughout ACC, so in_valid alone marks an accept
                    if (in_valid) begin
                        cnt_q <= cnt_d;
                        err_q <= err_d;
                        sum_q <= sum_d;
                        max_q <= max_d;
                        sat_q <= sat_d;
`ifdef SIGNED_ERR_EN
                        se_q  <= se_d;
`endif
                        if (last_s) begin
                            state_q <= ST_RPT;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RPT: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;
    assign sat       = sat_q;
`ifdef SIGNED_ERR_EN
    assign sum_se    = se_q;
`endif

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Self-checking bench for approx_mul_err_monitor: directed scenarios plus random windows
// scored against an arithmetic reference model. Build with SIGNED_ERR_EN to also check sum_se.
module tb_approx_mul_err_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a, b;
    logic [7:0] y;
    logic       start4, start256, start6;

    logic        rdy4, busy4, done4, sat4;
    logic [2:0]  err4;
    logic [15:0] sum4;
    logic [7:0]  max4;
    logic        rdy256, busy256, done256, sat256;
    logic [8:0]  err256;
    logic [15:0] sum256;
    logic [7:0]  max256;
    logic        rdy6, busy6, done6, sat6;
    logic [2:0]  err6;
    logic [5:0]  sum6;
    logic [7:0]  max6;
`ifdef SIGNED_ERR_EN
    logic signed [16:0] se4, se256;
    logic signed [6:0]  se6;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt4 = 0;
    int m_err, m_sum, m_max, m_sat, m_se;

    always #5 clk = ~clk;

    approx_mul_err_monitor #(.N(4), .WIN(4), .W_ACC(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid), .in_ready(rdy4),
        .a(a), .b(b), .y_approx(y), .busy(busy4), .done(done4), .err_count(err4),
        .sum_ed(sum4), .max_ed(max4),
`ifdef SIGNED_ERR_EN
        .sum_se(se4),
`endif
        .sat(sat4));

    approx_mul_err_monitor #(.N(4), .WIN(256), .W_ACC(16)) dut256 (
        .clk(clk), .rst_n(rst_n), .start(start256), .in_valid(in_valid), .in_ready(rdy256),
        .a(a), .b(b), .y_approx(y), .busy(busy256), .done(done256), .err_count(err256),
        .sum_ed(sum256), .max_ed(max256),
`ifdef SIGNED_ERR_EN
        .sum_se(se256),
`endif
        .sat(sat256));

    approx_mul_err_monitor #(.N(4), .WIN(4), .W_ACC(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .in_valid(in_valid), .in_ready(rdy6),
        .a(a), .b(b), .y_approx(y), .busy(busy6), .done(done6), .err_count(err6),
        .sum_ed(sum6), .max_ed(max6),
`ifdef SIGNED_ERR_EN
        .sum_se(se6),
`endif
        .sat(sat6));

    always @(negedge clk) begin
        if (done4 === 1'b1) done_cnt4 <= done_cnt4 + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 2x2 block that approximates 3x3 as 7; four blocks build the 4x4 recursive multiplier
    function automatic int m2(input int x, input int z);
        return (x == 3 && z == 3) ? 7 : x * z;
    endfunction

    function automatic int approx_mul(input int av, input int bv);
        int ah = av / 4, al = av % 4, bh = bv / 4, bl = bv % 4;
        return m2(ah, bh) * 16 + (m2(ah, bl) + m2(al, bh)) * 4 + m2(al, bl);
    endfunction

    task automatic m_clear();
        m_err = 0; m_sum = 0; m_max = 0; m_sat = 0; m_se = 0;
    endtask

    task automatic m_add(input int av, input int bv, input int yv, input int wacc);
        int e = av * bv - yv;
        int ed = (e < 0) ? -e : e;
        if (ed != 0) m_err++;
        if (ed > m_max) m_max = ed;
        m_sum += ed;
        if (m_sum > (1 << wacc) - 1) begin
            m_sum = (1 << wacc) - 1;
            m_sat = 1;
        end
        m_se += e;
        if (m_se > (1 << wacc) - 1) begin
            m_se = (1 << wacc) - 1;
            m_sat = 1;
        end else if (m_se < -(1 << wacc)) begin
            m_se = -(1 << wacc);
            m_sat = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int which);
        if (which == 4) start4 = 1'b1;
        else if (which == 256) start256 = 1'b1;
        else start6 = 1'b1;
        tick();
        start4 = 1'b0; start256 = 1'b0; start6 = 1'b0;
    endtask

    task automatic feed(input int av, input int bv, input int yv, input int wacc);
        a = 4'(av); b = 4'(bv); y = 8'(yv);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        m_add(av, bv, yv, wacc);
    endtask

    task automatic feed_rand(input int wacc);
        int av = $urandom_range(0, 15);
        int bv = $urandom_range(0, 15);
        int yv = ($urandom_range(0, 1) == 1) ? approx_mul(av, bv) : $urandom_range(0, 255);
        feed(av, bv, yv, wacc);
    endtask

    task automatic chk_dut4(input string tag);
        chk({tag, "_err"}, 32'(err4), m_err);
        chk({tag, "_sum"}, 32'(sum4), m_sum);
        chk({tag, "_max"}, 32'(max4), m_max);
        chk({tag, "_sat"}, 32'(sat4), m_sat);
`ifdef SIGNED_ERR_EN
        chk({tag, "_se"}, 32'(int'(se4)), m_se);
`endif
    endtask

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 1'b0; a = 4'd0; b = 4'd0; y = 8'd0;
        start4 = 1'b0; start256 = 1'b0; start6 = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        // Reset state, then an asynchronous reset in the middle of a window
        chk("rst_rdy", 32'(rdy4), 0);
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_done", 32'(done4), 0);
        chk("rst_err", 32'(err4), 0);
        do_start(4);
        chk("acc_busy", 32'(busy4), 1);
        chk("acc_rdy", 32'(rdy4), 1);
        feed(3, 3, 7, 16);
        chk("pre_async_err", 32'(err4), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rdy", 32'(rdy4), 0);
        chk("async_busy", 32'(busy4), 0);
        chk("async_err", 32'(err4), 0);
        chk("async_sum", 32'(sum4), 0);
        chk("async_max", 32'(max4), 0);
        chk("async_sat", 32'(sat4), 0);
        #2 rst_n = 1'b1;
        tick();

        // Directed WIN=4 window
        m_clear();
        do_start(4);
        feed(3, 3, 7, 16);
        feed(2, 2, 4, 16);
        feed(15, 15, 175, 16);
        chk("dir_done_early", 32'(done4), 0);
        feed(1, 0, 0, 16);
        chk("dir_done", 32'(done4), 1);
        chk("dir_rpt_rdy", 32'(rdy4), 0);
        chk("dir_rpt_busy", 32'(busy4), 0);
        chk("dir_err", 32'(err4), 2);
        chk("dir_sum", 32'(sum4), 52);
        chk("dir_max", 32'(max4), 50);
        tick();
        chk("dir_done_gone", 32'(done4), 0);
        tick();
        chk("dir_hold_sum", 32'(sum4), 52);

        // Exhaustive 4x4 sweep through the approximate multiplier, WIN=256
        m_clear();
        do_start(256);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                feed(i, j, approx_mul(i, j), 16);
        chk("sweep_done", 32'(done256), 1);
        chk("sweep_err", 32'(err256), 49);
        chk("sweep_max", 32'(max256), 50);
        chk("sweep_sat", 32'(sat256), 0);
        chk("sweep_sum", 32'(sum256), m_sum);
        tick();

        // Saturation with W_ACC=6
        m_clear();
        do_start(6);
        feed(15, 15, 175, 6);
        feed(15, 15, 175, 6);
        feed(0, 0, 0, 6);
        feed(0, 0, 0, 6);
        chk("sat_done", 32'(done6), 1);
        chk("sat_sum", 32'(sum6), 63);
        chk("sat_flag", 32'(sat6), 1);
        tick();
        chk("sat_sticky", 32'(sat6), 1);
        do_start(6);
        chk("sat_cleared", 32'(sat6), 0);
        chk("sat_sum_cleared", 32'(sum6), 0);

        // Gaps and ignored start pulses during ACC and RPT
        base = done_cnt4;
        m_clear();
        do_start(4);
        for (int k = 0; k < 4; k++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                start4 = 1'($urandom_range(0, 1));
                tick();
                chk("gap_err", 32'(err4), m_err);
                chk("gap_busy", 32'(busy4), 1);
            end
            start4 = 1'b1;
            feed_rand(16);
            start4 = 1'b0;
        end
        chk("gap_done", 32'(done4), 1);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("rpt_start_ignored", 32'(busy4), 0);
        tick();
        chk("rpt_start_still_idle", 32'(busy4), 0);
        chk("gap_one_done", 32'(done_cnt4 - base), 1);
        chk_dut4("gap");

        // Reset after 2 of 4 samples, then a fresh window
        base = done_cnt4;
        do_start(4);
        feed_rand(16);
        feed_rand(16);
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        tick();
        chk("abandon_no_done", 32'(done_cnt4 - base), 0);
        m_clear();
        do_start(4);
        for (int k = 0; k < 4; k++) feed_rand(16);
        chk("fresh_done", 32'(done4), 1);
        chk_dut4("fresh");
        tick();
        chk("fresh_one_done", 32'(done_cnt4 - base), 1);

        // Random windows
        for (int w = 0; w < 8; w++) begin
            m_clear();
            do_start(4);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) tick();
                feed_rand(16);
            end
            chk("rand_done", 32'(done4), 1);
            chk_dut4("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
